// File: rtl/calc_exec_unit.sv
// Multi-cycle signed arithmetic unit: SUM, SUB, MUL (shift-add), DIV/MOD (restoring) and SQRT.
// Define CALC_SQRT_EN to build the bit-pair square-root datapath; without it opcode 101 is invalid.
module calc_exec_unit #(
   parameter int N = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [N-1:0]     a,
   input  logic [N-1:0]     b,
   input  logic [2:0]       opcode,
   output logic [2*N-1:0]   result,
   output logic [N-1:0]     remainder,
   output logic             busy,
   output logic             valid,
   output logic [1:0]       err
);
   localparam int CW = $clog2(N + 1);

   localparam logic [2:0] OP_SUM  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_MUL  = 3'b010;
   localparam logic [2:0] OP_DIV  = 3'b011;
   localparam logic [2:0] OP_MOD  = 3'b100;
   localparam logic [2:0] OP_SQRT = 3'b101;

   localparam logic [1:0] E_OK   = 2'b00;
   localparam logic [1:0] E_DIV0 = 2'b01;
   localparam logic [1:0] E_NEG  = 2'b10;
   localparam logic [1:0] E_OP   = 2'b11;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state, state_next;
   logic [N-1:0]    a_r, b_r;
   logic [2:0]      op_r;
   logic [CW-1:0]   cnt;
   logic [2*N-1:0]  acc;      // MUL partial product, multiplier in the low half
   logic [N-1:0]    quo;      // DIV dividend/quotient shifter, SQRT operand shifter
   logic [N-1:0]    rem_w;

   logic            accept, calc_last, neg_ab;
   logic [1:0]      err_code;
   logic [CW-1:0]   lat_m1;
   logic [N-1:0]    in_mag_a, in_mag_b, mag_a, mag_b;
   logic [2*N-1:0]  a_ext, b_ext;
   logic [N:0]      mul_sum, div_shift, div_diff;
   logic [2*N-1:0]  p_next, q_ext;
   logic [N-1:0]    q_next, rem_next, rem_sgn;
   logic [2*N-1:0]  res_final;
   logic [N-1:0]    rem_final;

   assign accept   = start && (state != CALC);
   assign in_mag_a = a[N-1] ? -a : a;
   assign in_mag_b = b[N-1] ? -b : b;
   assign mag_a    = a_r[N-1] ? -a_r : a_r;
   assign mag_b    = b_r[N-1] ? -b_r : b_r;
   assign neg_ab   = a_r[N-1] ^ b_r[N-1];
   assign a_ext    = {{N{a_r[N-1]}}, a_r};
   assign b_ext    = {{N{b_r[N-1]}}, b_r};

   // Shift-add step: conditionally add the multiplicand into the upper half, then shift right.
   assign mul_sum  = {1'b0, acc[2*N-1:N]} + {1'b0, mag_a};
   assign p_next   = acc[0] ? {mul_sum, acc[N-1:1]} : {1'b0, acc[2*N-1:1]};

   // Restoring division step: keep the trial difference only when it did not go negative.
   assign div_shift = {rem_w, quo[N-1]};
   assign div_diff  = div_shift - {1'b0, mag_b};
   assign rem_next  = div_diff[N] ? div_shift[N-1:0] : div_diff[N-1:0];
   assign q_next    = {quo[N-2:0], ~div_diff[N]};
   assign q_ext     = {{N{1'b0}}, q_next};
   assign rem_sgn   = a_r[N-1] ? -rem_next : rem_next;

`ifdef CALC_SQRT_EN
   logic [N+1:0]    sq_r, sq_shift, sq_r_next, sq_r_fin;
   logic [N/2-1:0]  sq_q, sq_q_next;

   // Non-restoring bit pair: subtract (4q+1) after a non-negative remainder, else add (4q+3).
   assign sq_shift  = {sq_r[N-1:0], quo[N-1:N-2]};
   assign sq_r_next = sq_r[N+1] ? sq_shift + {{(N/2){1'b0}}, sq_q, 2'b11}
                                : sq_shift - {{(N/2){1'b0}}, sq_q, 2'b01};
   assign sq_q_next = {sq_q[N/2-2:0], ~sq_r_next[N+1]};
   assign sq_r_fin  = sq_r_next[N+1] ? sq_r_next + {{(N/2+1){1'b0}}, sq_q_next, 1'b1} : sq_r_next;
`endif

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      err_code = E_OK;
      case (op_r)
         OP_SUM, OP_SUB, OP_MUL: ;
         OP_DIV, OP_MOD:         if (b_r == '0) err_code = E_DIV0;
`ifdef CALC_SQRT_EN
         OP_SQRT:                if (a_r[N-1]) err_code = E_NEG;
`endif
         default:                err_code = E_OP;
      endcase

      lat_m1 = '0;
      if (err_code == E_OK) begin
         case (op_r)
            OP_MUL, OP_DIV, OP_MOD: lat_m1 = CW'(N - 1);
`ifdef CALC_SQRT_EN
            OP_SQRT:                lat_m1 = CW'(N / 2 - 1);
`endif
            default:                ;
         endcase
      end
   end

   assign calc_last = (state == CALC) && (cnt == lat_m1);

   always_comb begin
      res_final = '0;
      rem_final = '0;
      if (err_code == E_OK) begin
         case (op_r)
            OP_SUM: res_final = a_ext + b_ext;
            OP_SUB: res_final = a_ext - b_ext;
            OP_MUL: res_final = neg_ab ? -p_next : p_next;
            OP_DIV: begin
               res_final = neg_ab ? -q_ext : q_ext;
               rem_final = rem_sgn;
            end
            OP_MOD: res_final = {{N{rem_sgn[N-1]}}, rem_sgn};
`ifdef CALC_SQRT_EN
            OP_SQRT: begin
               res_final = {{(2*N - N/2){1'b0}}, sq_q_next};
               rem_final = sq_r_fin[N-1:0];
            end
`endif
            default: ;
         endcase
      end
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      valid      = 1'b0;
      case (state)
         IDLE: if (start) state_next = CALC;
         CALC: begin
            busy = 1'b1;
            if (calc_last) state_next = DONE;
         end
         DONE: begin
            valid = 1'b1;
            if (start) state_next = CALC;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r       <= '0;
         b_r       <= '0;
         op_r      <= '0;
         cnt       <= '0;
         acc       <= '0;
         quo       <= '0;
         rem_w     <= '0;
         result    <= '0;
         remainder <= '0;
         err       <= E_OK;
`ifdef CALC_SQRT_EN
         sq_r      <= '0;
         sq_q      <= '0;
`endif
      end else if (accept) begin
         a_r   <= a;
         b_r   <= b;
         op_r  <= opcode;
         cnt   <= '0;
         err   <= E_OK;
         acc   <= {{N{1'b0}}, in_mag_b};
         quo   <= in_mag_a;
         rem_w <= '0;
`ifdef CALC_SQRT_EN
         if (opcode == OP_SQRT) quo <= a;
         sq_r  <= '0;
         sq_q  <= '0;
`endif
      end else if (state == CALC) begin
         cnt   <= cnt + CW'(1);
         acc   <= p_next;
         quo   <= q_next;
         rem_w <= rem_next;
`ifdef CALC_SQRT_EN
         if (op_r == OP_SQRT) quo <= {quo[N-3:0], 2'b00};
         sq_r  <= sq_r_next;
         sq_q  <= sq_q_next;
`endif
         if (calc_last) begin
            result    <= res_final;
            remainder <= rem_final;
            err       <= err_code;
         end
      end
   end
endmodule

// File: tb/tb_calc_exec_unit.sv
// Self-checking bench for calc_exec_unit: directed corner cases plus random operations
// checked against an integer-arithmetic reference model; honours CALC_SQRT_EN.
module tb_calc_exec_unit;
   localparam int N = 12;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [N-1:0]   a, b;
   logic [2:0]     opcode;
   logic [2*N-1:0] result;
   logic [N-1:0]   remainder;
   logic           busy, valid;
   logic [1:0]     err;

   int n_checks = 0;
   int n_fail   = 0;
   int last_res, last_rem;

   calc_exec_unit #(.N(N)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .opcode(opcode),
      .result(result), .remainder(remainder), .busy(busy), .valid(valid), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic logic signed [31:0] res_s();
      return {{(32-2*N){result[2*N-1]}}, result};
   endfunction

   function automatic logic signed [31:0] rem_s();
      return {{(32-N){remainder[N-1]}}, remainder};
   endfunction

   // Reference: plain integer arithmetic (SV / and % truncate toward zero, % follows the dividend).
   task automatic model(input int av, input int bv, input int op,
                        output int r, output int rm, output int e, output int lat);
      r = 0; rm = 0; e = 0; lat = 1;
      case (op)
         0: r = av + bv;
         1: r = av - bv;
         2: begin r = av * bv; lat = N; end
         3: if (bv == 0) e = 1; else begin r = av / bv; rm = av % bv; lat = N; end
         4: if (bv == 0) e = 1; else begin r = av % bv; lat = N; end
         5: begin
`ifdef CALC_SQRT_EN
            if (av < 0) e = 2;
            else begin
               int s;
               s = 0;
               while ((s + 1) * (s + 1) <= av) s++;
               r = s; rm = av - s * s; lat = N / 2;
            end
`else
            e = 3;
`endif
         end
         default: e = 3;
      endcase
      if (e != 0) begin r = 0; rm = 0; lat = 1; end
   endtask

   task automatic do_op(input string tag, input int av, input int bv, input int op, input int glitch_at);
      int er, erm, ee, elat, lat, busy_cyc;
      model(av, bv, op, er, erm, ee, elat);
      @(negedge clk);
      a = av[N-1:0]; b = bv[N-1:0]; opcode = op[2:0]; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, ":valid_clr"}, {31'b0, valid}, 0);
      check({tag, ":err_clr"}, {30'b0, err}, 0);
      lat = 0; busy_cyc = 0;
      while (valid !== 1'b1 && lat < 4 * N) begin
         if (busy === 1'b1) busy_cyc++;
         start = (lat + 1 == glitch_at);
         if (start) begin a = ~a; b = ~b; opcode = 3'b000; end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      check({tag, ":latency"}, lat, elat);
      check({tag, ":busy_cycles"}, busy_cyc, elat);
      check({tag, ":result"}, res_s(), er);
      check({tag, ":remainder"}, rem_s(), erm);
      check({tag, ":err"}, {30'b0, err}, ee);
      last_res = er;
      last_rem = erm;
   endtask

   initial begin
      int vcount, op, av, bv;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; opcode = '0;
      #1;
      check("reset:result", res_s(), 0);
      check("reset:remainder", rem_s(), 0);
      check("reset:busy", {31'b0, busy}, 0);
      check("reset:valid", {31'b0, valid}, 0);
      check("reset:err", {30'b0, err}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      do_op("sum", -129, 456, 0, -1);
      check("sum:const", res_s(), 327);
      repeat (3) @(negedge clk);
      check("hold:valid", {31'b0, valid}, 1);
      check("hold:result", res_s(), last_res);

      do_op("mul_glitch", -129, 456, 2, 5);
      check("mul:const", res_s(), -58824);
      do_op("div", -129, 4, 3, -1);
      check("div:const_q", res_s(), -32);
      check("div:const_r", rem_s(), -1);
      do_op("mod", -129, 4, 4, -1);
      check("mod:const", res_s(), -1);
      do_op("div0", -129, 0, 3, -1);
      check("div0:err", {30'b0, err}, 1);
      do_op("mod0", 5, 0, 4, -1);
      do_op("div_min", -2048, -1, 3, -1);
      check("div_min:const", res_s(), 2048);
      do_op("mod_neg_b", 100, -7, 4, -1);
      do_op("sub_edge", -2048, 2047, 1, -1);
      do_op("mul_min", -2048, -2048, 2, -1);
      do_op("mul_zero", 0, -77, 2, -1);
      do_op("sqrt456", 456, 99, 5, -1);
`ifdef CALC_SQRT_EN
      check("sqrt:const_q", res_s(), 21);
      check("sqrt:const_r", rem_s(), 15);
`else
      check("sqrt_off:err", {30'b0, err}, 3);
`endif
      do_op("sqrt_neg", -4, 0, 5, -1);
      do_op("sqrt0", 0, 0, 5, -1);
      do_op("sqrt_max", 2047, 0, 5, -1);
      do_op("op111", 3, 4, 7, -1);
      check("op111:err", {30'b0, err}, 3);
      do_op("op110", 3, 4, 6, -1);

      for (int i = 0; i < 40; i++) begin
         op = int'($urandom_range(0, 7));
         av = int'($urandom_range(0, 4095)) - 2048;
         bv = int'($urandom_range(0, 4095)) - 2048;
         if ($urandom_range(0, 7) == 0) bv = 0;
         if (op == 5 && $urandom_range(0, 3) != 0 && av < 0) av = -av - 1;
         do_op("random", av, bv, op, -1);
      end

      // Abort a multiply mid-flight with an asynchronous reset between edges.
      do_op("pre_rst", 77, 5, 0, -1);
      @(negedge clk);
      a = 12'hF7F; b = 12'h1C8; opcode = 3'b010; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst:result", res_s(), 0);
      check("midrst:remainder", rem_s(), 0);
      check("midrst:busy", {31'b0, busy}, 0);
      check("midrst:valid", {31'b0, valid}, 0);
      check("midrst:err", {30'b0, err}, 0);
      vcount = 0;
      repeat (3) begin @(negedge clk); if (valid === 1'b1) vcount++; end
      rst = 1'b0;
      repeat (N + 4) begin @(negedge clk); if (valid === 1'b1 || busy === 1'b1) vcount++; end
      check("midrst:no_valid", vcount, 0);
      do_op("post_rst_sum", -129, 456, 0, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/calc_exec_unit.md
CALC_EXEC_UNIT -- requirements
Module: calc_exec_unit

Interface
REQ-001 Parameter: N, 12, operand width; SHALL be even and at least 4.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  operation request, sampled each rising edge; driven by the input stage's done.
REQ-005 a  input  N  signed operand A, two's complement.
REQ-006 b  input  N  signed operand B, two's complement; ignored for SQRT.
REQ-007 opcode  input  3  000 SUM, 001 SUB, 010 MUL, 011 DIV, 100 MOD, 101 SQRT, 110/111 invalid.
REQ-008 result  output  2N  signed result, registered.
REQ-009 remainder  output  N  signed remainder for DIV and SQRT; 0 otherwise.
REQ-010 busy  output  1  high while in CALC.
REQ-011 valid  output  1  high while in DONE; result, remainder and err stable while high.
REQ-012 err  output  2  00 ok, 01 divide by zero, 10 SQRT of negative, 11 invalid opcode.

Function
REQ-013 FSM states are IDLE, CALC and DONE; reset state is IDLE.
REQ-014 In IDLE or DONE, start=1 at edge k SHALL latch a, b and opcode, clear valid, and enter CALC.
REQ-015 start while in CALC SHALL be ignored, with no effect on the operands or the cycle count.
REQ-016 SUM/SUB: result = a+b or a-b, sign-extended to 2N; enter DONE at edge k+1.
REQ-017 MUL: shift-add on magnitudes, one bit per cycle; signed product applied on the final cycle; DONE at edge k+N.
REQ-018 DIV/MOD: restoring division on magnitudes, one bit per cycle; DONE at edge k+N.
REQ-019 DIV/MOD rounding: quotient truncates toward zero; remainder takes the sign of a.
REQ-020 DIV/MOD outputs: DIV puts the quotient in result and the remainder in remainder; MOD puts the remainder, sign-extended, in result.
REQ-021 -2^(N-1) DIV -1 SHALL give +2^(N-1) in result, with no error.
REQ-022 SQRT: bit-pair non-restoring integer square root of a; result = floor(sqrt(a)), remainder = a - result^2; DONE at edge k+N/2.
REQ-023 Error cases: b=0 for DIV/MOD gives err=01; a<0 for SQRT gives err=10; opcode 110/111 gives err=11.
REQ-024 On any error, result=0 and remainder=0, with DONE at edge k+1.
REQ-025 busy=1 exactly in CALC; valid=1 exactly in DONE.
REQ-026 DONE SHALL be held until the next accepted start or RST.
REQ-027 err SHALL be cleared to 00 when start is accepted.
REQ-028 SUM/SUB SHALL never overflow, because the result width is 2N.

Reset
REQ-029 RST=1 SHALL immediately, regardless of clock, force IDLE and clear result, remainder, busy, valid, err, the latched operands and the iteration counter.
REQ-030 RST asserted mid-CALC SHALL abort the operation; no valid pulse is produced.
REQ-031 After RST deasserts, the first start SHALL be accepted on the next rising edge.

Configuration
REQ-032 Macro CALC_SQRT_EN: when defined, the SQRT datapath is compiled in and behaves per REQ-022.
REQ-033 When CALC_SQRT_EN is undefined, no SQRT logic is built; opcode 101 is treated as invalid (err=11, DONE at edge k+1).

Verification
REQ-034 N=12, a=-129, b=456, SUM, start at edge k -> valid at k+1, result=327, err=00, busy high for exactly 1 cycle.
REQ-035 a=-129, b=456, MUL -> busy for 12 cycles, valid at k+12, result=-58824; a start at k+5 is ignored.
REQ-036 a=-129, b=4, DIV -> result=-32, remainder=-1; same operands with MOD -> result=-1; then b=0 with DIV -> err=01, result=0, valid at k+1.
REQ-037 SQRT with a=456 and CALC_SQRT_EN defined -> valid at k+6, result=21, remainder=15; a=-4 -> err=10.
REQ-038 SQRT with a=456 and CALC_SQRT_EN undefined -> err=11; opcode 111 -> err=11 in both builds.
REQ-039 Start MUL, assert RST at k+4 between clock edges -> outputs 0 immediately, valid never rises; a SUM start after release completes normally.
